// File: rtl/uart_pkg.sv
// Shared types and default sizes for the UART receive FIFO.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;

  // Per-frame error tags reported by the receiver.
  typedef struct packed {
    logic parity_err;
    logic framing_err;
  } uart_tags_t;

  localparam int UART_TAG_W = $bits(uart_tags_t);

  // One stored entry at the default character width: data plus error tags.
  typedef struct packed {
    logic [UART_DATA_W-1:0] data;
    uart_tags_t             tags;
  } uart_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART receive FIFO.
// Writes are synchronous. Reads are asynchronous, which gives fall-through behaviour at the head.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_DATA_W,
  parameter int DEPTH = UART_FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the pushed entry at the write pointer.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with a first-word fall-through read side.
// A push happens only on the rising edge of done. Pushes that arrive while the FIFO is full, with no pop in the same cycle, are dropped and set a sticky overflow flag.
// Optional macro UART_RX_ERR_TAG_EN: when defined, each entry also stores its parity and framing error tags.
// When the macro is undefined, frames with either error bit set are discarded, and the tag outputs read 0.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_W,
  parameter int DEPTH      = UART_FIFO_DEPTH,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  parity_error,
  input  logic                  framing_error,
  input  logic                  rd_ready,
  input  logic                  clr_ovf,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_parity_err,
  output logic                  rd_framing_err,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);

`ifdef UART_RX_ERR_TAG_EN
  localparam int ENTRY_W = DATA_WIDTH + UART_TAG_W;
`else
  localparam int ENTRY_W = DATA_WIDTH;
`endif

  logic          done_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic               push_req;
  logic               push_ok;
  logic               pop;
  logic               ovf_set;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign rd_valid = !empty;
  assign count    = count_q;
  assign overflow = overflow_q;

  assign pop = rd_valid && rd_ready;

`ifdef UART_RX_ERR_TAG_EN
  uart_tags_t wr_tags;
  uart_tags_t rd_tags;

  assign wr_tags.parity_err  = parity_error;
  assign wr_tags.framing_err = framing_error;
  assign push_req            = done && !done_q;
  assign wr_entry            = {data_out, wr_tags};
  assign rd_tags             = rd_entry[UART_TAG_W-1:0];
  assign rd_data             = rd_entry[ENTRY_W-1 -: DATA_WIDTH];
  assign rd_parity_err       = rd_tags.parity_err;
  assign rd_framing_err      = rd_tags.framing_err;
`else
  // A corrupted frame is treated as if it never arrived, so it cannot cause an overflow either.
  assign push_req       = done && !done_q && !parity_error && !framing_error;
  assign wr_entry       = data_out;
  assign rd_data        = rd_entry;
  assign rd_parity_err  = 1'b0;
  assign rd_framing_err = 1'b0;
`endif

  // A concurrent pop frees the slot, so a push is accepted even when the FIFO is full.
  assign push_ok = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;

  uart_fifo_mem #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk    (clk),
    .we_i   (push_ok),
    .waddr_i(wr_ptr_q),
    .wdata_i(wr_entry),
    .raddr_i(rd_ptr_q),
    .rdata_o(rd_entry)
  );

  // Next-state logic for the pointers, the occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CW'(1);
    end
    // A new overflow wins over a clear in the same cycle.
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // State registers.
  // The edge detector resets to 1, so a done that is already high when reset is released does not push.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q     <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      done_q     <= done;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo at its default size (8-bit data, 16 entries).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       done;
  logic [7:0] data_out;
  logic       parity_error;
  logic       framing_error;
  logic       rd_ready;
  logic       clr_ovf;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_parity_err;
  logic       rd_framing_err;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;

  int tests_run    = 0;
  int tests_failed = 0;

  uart_rx_fifo #(
    .DATA_WIDTH(8),
    .DEPTH(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .done          (done),
    .data_out      (data_out),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .rd_ready      (rd_ready),
    .clr_ovf       (clr_ovf),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_parity_err (rd_parity_err),
    .rd_framing_err(rd_framing_err),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  // Every task starts and ends at a falling edge. Inputs are driven there, and outputs are sampled there.

  // One frame: done is high for one cycle, then low for one cycle.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic fe);
    data_out      = d;
    parity_error  = pe;
    framing_error = fe;
    done          = 1'b1;
    @(negedge clk);
    done          = 1'b0;
    parity_error  = 1'b0;
    framing_error = 1'b0;
    @(negedge clk);
    $display("[TB] frame data=%02h pe=%0b fe=%0b -> count=%0d ovf=%0b", d, pe, fe, count, overflow);
  endtask

  // Pop n entries, expecting the values first, first+1, and so on.
  task automatic drain(input logic [7:0] first, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      logic [7:0] exp_d;
      exp_d = first + 8'(i);
      tests_run++;
      if (rd_valid !== 1'b1 || rd_data !== exp_d) begin
        tests_failed++;
        $display("FAIL %s_read%0d: got valid=%0b data=%02h, expected valid=1 data=%02h",
                 tag, i, rd_valid, rd_data, exp_d);
      end
      $display("[TB] read %s #%0d data=%02h", tag, i, rd_data);
      rd_ready = 1'b1;
      @(negedge clk);
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || rd_valid !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got count=%0d empty=%0b full=%0b valid=%0b ovf=%0b, expected 0 1 0 0 0",
               count, empty, full, rd_valid, overflow);
    end
    @(negedge clk);
  endtask

  // done held high for three cycles must produce a single push.
  task automatic test_long_done();
    data_out = 8'hA5;
    done     = 1'b1;
    @(negedge clk);
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || count !== 5'd1) begin
      tests_failed++;
      $display("FAIL long_done_first: got valid=%0b data=%02h count=%0d, expected 1 a5 1",
               rd_valid, rd_data, count);
    end
    repeat (2) @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    tests_run++;
    if (count !== 5'd1) begin
      tests_failed++;
      $display("FAIL long_done_count: got %0d, expected 1", count);
    end
    drain(8'hA5, 1, "long_done");
    tests_run++;
    if (empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL long_done_empty: got %0b, expected 1", empty);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0);
    tests_run++;
    if (full !== 1'b1 || overflow !== 1'b1 || count !== 5'd16) begin
      tests_failed++;
      $display("FAIL overflow_flags: got full=%0b ovf=%0b count=%0d, expected 1 1 16", full, overflow, count);
    end
    drain(8'h00, 16, "overflow");
    tests_run++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      tests_failed++;
      $display("FAIL overflow_ff_absent: got empty=%0b count=%0d, expected 1 0", empty, count);
    end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow_clear: got %0b, expected 0", overflow);
    end
  endtask

  // Push while full, with a pop in the same cycle.
  task automatic test_push_pop_full();
    for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b0, 1'b0);
    data_out = 8'h55;
    done     = 1'b1;
    rd_ready = 1'b1;
    @(negedge clk);
    done     = 1'b0;
    rd_ready = 1'b0;
    tests_run++;
    if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL push_pop_full: got count=%0d full=%0b ovf=%0b, expected 16 1 0", count, full, overflow);
    end
    @(negedge clk);
    drain(8'h21, 15, "push_pop");
    drain(8'h55, 1, "push_pop_last");
    tests_run++;
    if (empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL push_pop_empty: got %0b, expected 1", empty);
    end
  endtask

  task automatic test_error_tag();
    send_frame(8'h3C, 1'b0, 1'b1);
    send_frame(8'h3D, 1'b1, 1'b0);
`ifdef UART_RX_ERR_TAG_EN
    tests_run++;
    if (count !== 5'd2 || rd_data !== 8'h3C || rd_framing_err !== 1'b1 || rd_parity_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL tag_framing: got count=%0d data=%02h fe=%0b pe=%0b, expected 2 3c 1 0",
               count, rd_data, rd_framing_err, rd_parity_err);
    end
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    tests_run++;
    if (rd_data !== 8'h3D || rd_framing_err !== 1'b0 || rd_parity_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL tag_parity: got data=%02h fe=%0b pe=%0b, expected 3d 0 1",
               rd_data, rd_framing_err, rd_parity_err);
    end
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
`else
    tests_run++;
    if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL tag_discard: got count=%0d empty=%0b ovf=%0b, expected 0 1 0", count, empty, overflow);
    end
`endif
    send_frame(8'h3E, 1'b0, 1'b0);
    tests_run++;
    if (count !== 5'd1 || rd_data !== 8'h3E || rd_parity_err !== 1'b0 || rd_framing_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL tag_clean: got count=%0d data=%02h pe=%0b fe=%0b, expected 1 3e 0 0",
               count, rd_data, rd_parity_err, rd_framing_err);
    end
    drain(8'h3E, 1, "tag_clean");
  endtask

  // A clear in the same cycle as a new overflow must leave overflow set.
  task automatic test_clr_ovf();
    for (int i = 0; i < 16; i++) send_frame(8'h40 + 8'(i), 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0);
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL clr_ovf_set: got %0b, expected 1", overflow);
    end
    clr_ovf  = 1'b1;
    data_out = 8'hEE;
    done     = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    done    = 1'b0;
    tests_run++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      tests_failed++;
      $display("FAIL clr_ovf_collide: got ovf=%0b count=%0d, expected 1 16", overflow, count);
    end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL clr_ovf_alone: got %0b, expected 0", overflow);
    end
    send_frame(8'hDD, 1'b0, 1'b0);
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL clr_ovf_reset: got %0b, expected 1", overflow);
    end
  endtask

  // Reset at count 5 while done is rising. A push must wait for a fresh rising edge of done.
  task automatic test_reset_while_done();
    drain(8'h40, 11, "pre_reset");
    tests_run++;
    if (count !== 5'd5 || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_state: got count=%0d ovf=%0b, expected 5 1", count, overflow);
    end
    data_out = 8'h99;
    done     = 1'b1;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_done_state: got count=%0d empty=%0b ovf=%0b valid=%0b, expected 0 1 0 0",
               count, empty, overflow, rd_valid);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (count !== 5'd0) begin
      tests_failed++;
      $display("FAIL rst_done_held: got count=%0d, expected 0", count);
    end
    done = 1'b0;
    @(negedge clk);
    data_out = 8'h77;
    done     = 1'b1;
    @(negedge clk);
    done = 1'b0;
    tests_run++;
    if (count !== 5'd1 || rd_data !== 8'h77) begin
      tests_failed++;
      $display("FAIL rst_done_repush: got count=%0d data=%02h, expected 1 77", count, rd_data);
    end
    @(negedge clk);
    drain(8'h77, 1, "repush");
  endtask

  initial begin
    rst           = 1'b1;
    done          = 1'b0;
    data_out      = 8'h00;
    parity_error  = 1'b0;
    framing_error = 1'b0;
    rd_ready      = 1'b0;
    clr_ovf       = 1'b0;
    @(negedge clk);
    test_reset();
    test_long_done();
    test_overflow();
    test_push_pop_full();
    test_error_tag();
    test_clr_ovf();
    test_reset_while_done();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of a received character.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; power of two, 2 to 256.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic (receiver clock domain).
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port done, input, 1, receiver frame-complete indication; high for 1 or more cycles per frame.
REQ-006 SHALL have port data_out, input, DATA_WIDTH, received character, valid while done is high.
REQ-007 SHALL have port parity_error, input, 1, receiver parity error for the current frame.
REQ-008 SHALL have port framing_error, input, 1, receiver stop-bit error for the current frame.
REQ-009 SHALL have port rd_ready, input, 1, consumer accepts the head entry.
REQ-010 SHALL have port clr_ovf, input, 1, clears the sticky overflow flag.
REQ-011 SHALL have port rd_valid, output, 1, head entry available.
REQ-012 SHALL have port rd_data, output, DATA_WIDTH, head character.
REQ-013 SHALL have port rd_parity_err, output, 1, parity tag of the head entry.
REQ-014 SHALL have port rd_framing_err, output, 1, framing tag of the head entry.
REQ-015 SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.
REQ-016 SHALL have ports full and empty, output, 1 each, occupancy == DEPTH and occupancy == 0.
REQ-017 SHALL have port overflow, output, 1, sticky: a frame was lost because the FIFO was full.

Function
REQ-018 SHALL generate a push on the rising edge of done only (done high now, low the previous cycle), so one frame gives exactly one push however long done stays high.
REQ-019 SHALL sample data_out, parity_error and framing_error in the push cycle.
REQ-020 SHALL operate as first-word fall-through: rd_valid = !empty; rd_data and tags show the head entry combinationally from storage.
REQ-021 SHALL pop when rd_valid && rd_ready; rd_ready while empty SHALL have no effect.
REQ-022 SHALL write a pushed entry at wr_ptr, readable one cycle later (push-to-rd_valid latency 1 cycle when empty).
REQ-023 SHALL accept a push when full if a pop occurs in the same cycle; count stays DEPTH.
REQ-024 SHALL on simultaneous push and pop when not full leave count unchanged and advance both pointers.
REQ-025 SHALL on push when full with no pop drop the frame, leave storage and count unchanged, and set overflow.
REQ-026 SHALL clear overflow on clr_ovf; when a new overflow occurs in the same cycle as clr_ovf, overflow SHALL remain set.
REQ-027 SHALL wrap pointers modulo DEPTH; count SHALL never exceed DEPTH or underflow.

Reset
REQ-028 SHALL, on rst high at a clk edge, clear pointers, count=0, empty=1, full=0, rd_valid=0, overflow=0, and the done edge-detect register to 1, so a done already high at reset release gives no push.
REQ-029 SHALL give rst priority over any push, pop or clr_ovf in the same cycle; stored data need not be cleared.

Configuration
REQ-030 SHALL honour macro UART_RX_ERR_TAG_EN.
REQ-031 SHALL, with UART_RX_ERR_TAG_EN defined, store both error bits per entry and drive them on rd_parity_err and rd_framing_err.
REQ-032 SHALL, without it, discard frames with either error bit set (no push, no overflow), store data only, and tie rd_parity_err and rd_framing_err to 0.

Structure
REQ-033 SHALL take the entry record type (data plus error tags) and default width constants from shared package uart_pkg.
REQ-034 SHALL put storage in one sub-module, uart_fifo_mem: a synchronous-write, asynchronous-read register array.

Verification
REQ-035 SHALL check: done high for 3 cycles with data_out=0xA5 -> exactly 1 entry; rd_valid 1 cycle later; rd_data=0xA5; count=1.
REQ-036 SHALL check: 16 frames 0x00..0x0F, then a 17th frame 0xFF, with rd_ready=0 -> full=1, overflow=1; reads return 0x00..0x0F in order; 0xFF is absent.
REQ-037 SHALL check: full FIFO, push 0x55 in the same cycle as a pop -> count stays 16; 0x55 is the last entry read; overflow stays 0.
REQ-038 SHALL check: framing_error=1 on frame 0x3C -> with the macro, entry 0x3C has rd_framing_err=1; without it, no entry and count=0.
REQ-039 SHALL check: rst asserted at count=5 while done is high -> next cycle count=0, empty=1, overflow=0; no push until done falls and rises again.
REQ-040 SHALL check: clr_ovf in the same cycle as a new overflow -> overflow=1; clr_ovf alone on the next cycle -> overflow=0.
